// File: rtl/pattern_scheduler_if.sv
// Bundle between a pattern_scheduler and its environment: requester-side request/config/status
// signals plus the shared blink-pattern generator control/status signals.
interface pattern_scheduler_if #(
   parameter int NREQ = 3,
   parameter int TW   = 32,
   parameter int RW   = 8
);
   logic [NREQ-1:0]    req;
   logic [NREQ*TW-1:0] req_ontime;
   logic [NREQ*TW-1:0] req_offtime;
   logic [NREQ*RW-1:0] req_reps;
   logic [NREQ-1:0]    grant;
   logic [NREQ-1:0]    done;
   logic [NREQ-1:0]    aborted;
   logic               busy;
   logic [TW-1:0]      pat_ontime;
   logic [TW-1:0]      pat_offtime;
   logic [RW-1:0]      pat_reps;
   logic               pat_enable;
   logic               pat_done;

   // Environment side: requesters plus the pattern generator.
   modport master (
      output req, req_ontime, req_offtime, req_reps, pat_done,
      input  grant, done, aborted, busy, pat_ontime, pat_offtime, pat_reps, pat_enable
   );

   // Scheduler side.
   modport slave (
      input  req, req_ontime, req_offtime, req_reps, pat_done,
      output grant, done, aborted, busy, pat_ontime, pat_offtime, pat_reps, pat_enable
   );
endinterface

// File: rtl/pattern_scheduler.sv
// Fixed-priority sharer of one blink-pattern generator among NREQ requesters (index 0 wins).
// Optional macro PATTERN_PREEMPT_EN lets a higher-priority request abort a running pattern.
module pattern_scheduler #(
   parameter int NREQ       = 3,
   parameter int TW         = 32,
   parameter int RW         = 8,
   parameter int GAP_CYCLES = 4
) (
   input logic                i_hwclk,
   input logic                i_reset,
   pattern_scheduler_if.slave bus
);

   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;
   localparam logic [1:0] ST_GAP  = 2'd3;

   logic [1:0]      r_state;
   logic [NREQ-1:0] r_grant;
   logic [NREQ-1:0] r_done;
   logic [NREQ-1:0] r_aborted;
   logic [TW-1:0]   r_pat_ontime;
   logic [TW-1:0]   r_pat_offtime;
   logic [RW-1:0]   r_pat_reps;
   logic            r_pat_enable;
   logic            r_first_run;
   logic [GW-1:0]   r_gap_cnt;

   logic [NREQ-1:0] w_pick;
   logic            w_any_req;
   logic            w_win_req;
   logic [TW-1:0]   w_sel_ontime;
   logic [TW-1:0]   w_sel_offtime;
   logic [RW-1:0]   w_sel_reps;

   // Lowest set bit of req is the winner; its config slice is muxed one-hot.
   assign w_pick    = bus.req & (~bus.req + NREQ'(1));
   assign w_any_req = |bus.req;
   assign w_win_req = |(bus.req & r_grant);

   // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      w_sel_ontime  = '0;
      w_sel_offtime = '0;
      w_sel_reps    = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_pick[i]) begin
            w_sel_ontime  = bus.req_ontime[i*TW +: TW];
            w_sel_offtime = bus.req_offtime[i*TW +: TW];
            w_sel_reps    = bus.req_reps[i*RW +: RW];
         end
      end
   end

`ifdef PATTERN_PREEMPT_EN
   // r_grant - 1 masks every index above the winner's priority, i.e. the lower indices.
   logic w_higher_req;
   assign w_higher_req = |(bus.req & (r_grant - NREQ'(1)));
`endif

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_hwclk) begin
      if (i_reset) begin
         r_state       <= ST_IDLE;
         r_grant       <= '0;
         r_done        <= '0;
         r_aborted     <= '0;
         r_pat_ontime  <= '0;
         r_pat_offtime <= '0;
         r_pat_reps    <= '0;
         r_pat_enable  <= 1'b0;
         r_first_run   <= 1'b0;
         r_gap_cnt     <= '0;
      end else begin
         r_done    <= '0;
         r_aborted <= '0;
         case (r_state)
            ST_IDLE: begin
               if (w_any_req) begin
                  r_grant       <= w_pick;
                  r_pat_ontime  <= w_sel_ontime;
                  r_pat_offtime <= w_sel_offtime;
                  r_pat_reps    <= w_sel_reps;
                  r_state       <= ST_LOAD;
               end
            end

            ST_LOAD: begin
               // A zero-repetition pattern completes without ever enabling the generator.
               if (r_pat_reps == '0) begin
                  r_done    <= r_grant;
                  r_grant   <= '0;
                  r_gap_cnt <= GAP_LAST;
                  r_state   <= ST_GAP;
               end else begin
                  r_pat_enable <= 1'b1;
                  r_first_run  <= 1'b1;
                  r_state      <= ST_RUN;
               end
            end

            ST_RUN: begin
               r_first_run <= 1'b0;
               // pat_done on the first RUN cycle is left over from the previous pattern.
               if (!r_first_run && bus.pat_done) begin
                  r_done       <= r_grant;
                  r_grant      <= '0;
                  r_pat_enable <= 1'b0;
                  r_gap_cnt    <= GAP_LAST;
                  r_state      <= ST_GAP;
               end else if (!w_win_req) begin
                  r_grant      <= '0;
                  r_pat_enable <= 1'b0;
                  r_gap_cnt    <= GAP_LAST;
                  r_state      <= ST_GAP;
               end
`ifdef PATTERN_PREEMPT_EN
               else if (w_higher_req) begin
                  r_aborted    <= r_grant;
                  r_grant      <= '0;
                  r_pat_enable <= 1'b0;
                  r_gap_cnt    <= GAP_LAST;
                  r_state      <= ST_GAP;
               end
`endif
            end

            ST_GAP: begin
               if (r_gap_cnt == '0) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_gap_cnt <= r_gap_cnt - GW'(1);
               end
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.grant       = r_grant;
   assign bus.done        = r_done;
   assign bus.aborted     = r_aborted;
   assign bus.busy        = (r_state != ST_IDLE);
   assign bus.pat_ontime  = r_pat_ontime;
   assign bus.pat_offtime = r_pat_offtime;
   assign bus.pat_reps    = r_pat_reps;
   assign bus.pat_enable  = r_pat_enable;

   a_grant_onehot: assert property (@(posedge i_hwclk) disable iff (i_reset)
      $onehot0(r_grant));
   a_done_single: assert property (@(posedge i_hwclk) disable iff (i_reset)
      (r_done & $past(r_done)) == '0);
   a_abort_single: assert property (@(posedge i_hwclk) disable iff (i_reset)
      (r_aborted & $past(r_aborted)) == '0);
   a_enable_in_run: assert property (@(posedge i_hwclk) disable iff (i_reset)
      r_pat_enable == (r_state == ST_RUN));

endmodule

// File: tb/tb_pattern_scheduler.sv
// Self-checking bench for pattern_scheduler: table-driven single-grant transactions plus
// hand-written sequences for priority waiting, stale done, withdraw, reset and preemption.
module tb_pattern_scheduler;

   localparam int NREQ = 3;
   localparam int TW   = 32;
   localparam int RW   = 8;
   localparam int GAP  = 4;

   typedef struct {
      logic [NREQ-1:0] req;
      logic [RW-1:0]   reps;
      logic [TW-1:0]   on;
      logic [TW-1:0]   off;
      logic [NREQ-1:0] exp_grant;
      int              exp_lat;
      int              exp_en;
   } vec_t;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_err;

   logic gen_manual;
   logic manual_done;
   logic model_done;
   int   gen_cnt;

   vec_t vecs[7];

   pattern_scheduler_if #(.NREQ(NREQ), .TW(TW), .RW(RW)) bus ();

   pattern_scheduler #(
      .NREQ(NREQ), .TW(TW), .RW(RW), .GAP_CYCLES(GAP)
   ) dut (
      .i_hwclk (clk),
      .i_reset (rst),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Generator model: done rises after reps*(ontime+offtime) enabled cycles, clears when disabled.
   always @(posedge clk) begin
      if (rst || !bus.pat_enable) begin
         gen_cnt    <= 0;
         model_done <= 1'b0;
      end else begin
         gen_cnt    <= gen_cnt + 1;
         model_done <= (gen_cnt + 1 >= int'(bus.pat_reps) * (int'(bus.pat_ontime) + int'(bus.pat_offtime)));
      end
   end

   assign bus.pat_done = gen_manual ? manual_done : model_done;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [NREQ-1:0] req, input logic [RW-1:0] reps,
                               input logic [TW-1:0] on, input logic [TW-1:0] off,
                               input logic [NREQ-1:0] g, input int lat, input int en);
      vec_t v;
      v.req = req; v.reps = reps; v.on = on; v.off = off;
      v.exp_grant = g; v.exp_lat = lat; v.exp_en = en;
      return v;
   endfunction

   task automatic set_slice(input int i, input logic [TW-1:0] on, input logic [TW-1:0] off,
                            input logic [RW-1:0] reps);
      bus.req_ontime[i*TW +: TW]  = on;
      bus.req_offtime[i*TW +: TW] = off;
      bus.req_reps[i*RW +: RW]    = reps;
   endtask

   task automatic wait_idle(input string name, input int budget);
      for (int k = 0; k < budget && bus.busy; k++) @(negedge clk);
      check(name, bus.busy, 1'b0);
   endtask

   task automatic wait_done(input string name, input logic [NREQ-1:0] mask, input int budget);
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if ((bus.done & mask) != '0) break;
      end
      check(name, bus.done, mask);
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int en_first, en_cnt, done_at, idle_at;
      logic [NREQ-1:0] done_val;
      string tag;
      tag = $sformatf("vec%0d", idx);
      for (int i = 0; i < NREQ; i++) begin
         if (v.exp_grant[i]) set_slice(i, v.on, v.off, v.reps);
         else set_slice(i, 32'hDEAD_0000 | i, 32'hBEEF_0000 | i, 8'hE0 | RW'(i));
      end
      gen_manual = 1'b0;
      bus.req    = v.req;
      en_first = -1; en_cnt = 0; done_at = -1; idle_at = -1; done_val = '0;
      for (int c = 1; c <= 1000 && idle_at < 0; c++) begin
         @(negedge clk);
         if (c == 1) begin
            check({tag, " grant"}, bus.grant, v.exp_grant);
            check({tag, " pat_reps"}, bus.pat_reps, v.reps);
            check({tag, " pat_ontime"}, bus.pat_ontime, v.on);
            check({tag, " pat_offtime"}, bus.pat_offtime, v.off);
            check({tag, " busy"}, bus.busy, 1'b1);
         end
         if (bus.pat_enable) begin
            en_cnt++;
            if (en_first < 0) en_first = c;
         end
         if (done_at < 0 && bus.done != '0) begin
            done_at  = c;
            done_val = bus.done;
            bus.req  = '0;
            check({tag, " grant at done"}, bus.grant, '0);
            check({tag, " enable at done"}, bus.pat_enable, 1'b0);
         end else if (done_at > 0 && c == done_at + 1) begin
            check({tag, " done one cycle"}, bus.done, '0);
         end
         if (done_at > 0 && !bus.busy) idle_at = c;
      end
      check({tag, " done latency"}, done_at, v.exp_lat);
      check({tag, " done bit"}, done_val, v.exp_grant);
      check({tag, " enable rise"}, en_first, (v.exp_en == 0) ? -1 : 2);
      check({tag, " enable cycles"}, en_cnt, v.exp_en);
      check({tag, " gap length"}, idle_at, v.exp_lat + GAP);
      bus.req = '0;
   endtask

   initial begin
      logic [NREQ-1:0] seen;
      n_checks = 0; n_err = 0;
      gen_manual = 1'b0; manual_done = 1'b0;
      bus.req = '0; bus.req_ontime = '0; bus.req_offtime = '0; bus.req_reps = '0;

      vecs[0] = mk(3'b100, 8'd5,   32'd10, 32'd10, 3'b100, 103, 101);
      vecs[1] = mk(3'b011, 8'd2,   32'd1,  32'd1,  3'b001, 7,   5);
      vecs[2] = mk(3'b010, 8'd0,   32'd4,  32'd4,  3'b010, 2,   0);
      vecs[3] = mk(3'b111, 8'd1,   32'd3,  32'd2,  3'b001, 8,   6);
      vecs[4] = mk(3'b110, 8'd3,   32'd1,  32'd2,  3'b010, 12,  10);
      vecs[5] = mk(3'b100, 8'd255, 32'd1,  32'd1,  3'b100, 513, 511);
      vecs[6] = mk(3'b001, 8'd1,   32'd1,  32'd0,  3'b001, 4,   2);

      // Reset state.
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst grant", bus.grant, '0);
      check("rst done", bus.done, '0);
      check("rst aborted", bus.aborted, '0);
      check("rst busy", bus.busy, 1'b0);
      check("rst enable", bus.pat_enable, 1'b0);
      check("rst pat_reps", bus.pat_reps, '0);
      check("rst pat_ontime", bus.pat_ontime, '0);
      rst = 1'b0;
      @(negedge clk);

      foreach (vecs[i]) run_vec(i, vecs[i]);

      // Priority: req 011 grants 0 first, 1 waits out the gap.
      set_slice(0, 32'd1, 32'd1, 8'd1);
      set_slice(1, 32'd1, 32'd1, 8'd2);
      bus.req = 3'b011;
      @(negedge clk);
      check("prio first grant", bus.grant, 3'b001);
      wait_done("prio done0", 3'b001, 50);
      bus.req = 3'b010;
      seen = '0;
      repeat (GAP) begin
         @(negedge clk);
         seen |= bus.grant;
      end
      check("prio no grant in gap", seen, '0);
      @(negedge clk);
      check("prio second grant", bus.grant, 3'b010);
      wait_done("prio done1", 3'b010, 50);
      bus.req = '0;
      wait_idle("prio idle", 20);

      // Stale pat_done on the first RUN cycle is ignored.
      gen_manual = 1'b1; manual_done = 1'b1;
      set_slice(2, 32'd5, 32'd5, 8'd3);
      bus.req = 3'b100;
      repeat (3) @(negedge clk);
      check("stale enable", bus.pat_enable, 1'b1);
      check("stale ignored", bus.done, '0);
      @(negedge clk);
      check("stale then done", bus.done, 3'b100);
      bus.req = '0; manual_done = 1'b0;
      wait_idle("stale idle", 20);

      // pat_done and withdraw in the same cycle: completion wins.
      manual_done = 1'b0;
      bus.req = 3'b100;
      repeat (4) @(negedge clk);
      manual_done = 1'b1; bus.req = '0;
      @(negedge clk);
      check("tie done wins", bus.done, 3'b100);
      manual_done = 1'b0;
      wait_idle("tie idle", 20);
      gen_manual = 1'b0;

      // Withdraw mid-RUN: enable drops next edge, no done, 4-cycle gap.
      set_slice(2, 32'd10, 32'd10, 8'd5);
      bus.req = 3'b100;
      repeat (10) @(negedge clk);
      check("wd running", bus.pat_enable, 1'b1);
      bus.req = '0;
      @(negedge clk);
      check("wd enable", bus.pat_enable, 1'b0);
      check("wd grant", bus.grant, '0);
      seen = bus.done | bus.aborted;
      repeat (GAP - 1) begin
         @(negedge clk);
         seen |= bus.done | bus.aborted;
      end
      check("wd busy in gap", bus.busy, 1'b1);
      check("wd no pulse", seen, '0);
      @(negedge clk);
      check("wd idle", bus.busy, 1'b0);

      // Reset mid-RUN, request held: regrant after release.
      set_slice(0, 32'd10, 32'd10, 8'd5);
      bus.req = 3'b001;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mrst enable", bus.pat_enable, 1'b0);
      check("mrst grant", bus.grant, '0);
      check("mrst busy", bus.busy, 1'b0);
      check("mrst done", bus.done | bus.aborted, '0);
      check("mrst pat_reps", bus.pat_reps, '0);
      rst = 1'b0;
      @(negedge clk);
      check("mrst regrant", bus.grant, 3'b001);
      bus.req = '0;
      wait_idle("mrst idle", 20);

      // Higher-priority request arriving during RUN.
      set_slice(0, 32'd1, 32'd1, 8'd1);
      set_slice(2, 32'd10, 32'd10, 8'd5);
      bus.req = 3'b100;
      repeat (5) @(negedge clk);
      bus.req = 3'b101;
      @(negedge clk);
`ifdef PATTERN_PREEMPT_EN
      check("pre aborted", bus.aborted, 3'b100);
      check("pre grant drop", bus.grant, '0);
      check("pre enable drop", bus.pat_enable, 1'b0);
      repeat (GAP) @(negedge clk);
      @(negedge clk);
      check("pre new grant", bus.grant, 3'b001);
      wait_done("pre done0", 3'b001, 50);
      bus.req = '0;
`else
      check("nopre grant held", bus.grant, 3'b100);
      check("nopre aborted", bus.aborted, '0);
      wait_done("nopre done2", 3'b100, 200);
      bus.req = 3'b001;
      repeat (GAP) @(negedge clk);
      @(negedge clk);
      check("nopre new grant", bus.grant, 3'b001);
      wait_done("nopre done0", 3'b001, 50);
      bus.req = '0;
`endif
      wait_idle("pre idle", 300);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
